// File: rtl/crc_stream_if.sv
// Framed beat bus around crc_stream: producer-side beat, sop/eop and ready in,
// registered beat, framing and CRC verdict out.
interface crc_stream_if #(
  parameter int DW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d;
  logic          sop;
  logic          eop;
  logic          out_valid;
  logic [DW-1:0] d_out;
  logic          sop_out;
  logic          eop_out;
  logic          crc_ok;
  logic          crc_err;

  modport master (
    output in_valid, d, sop, eop,
    input  in_ready, out_valid, d_out, sop_out, eop_out, crc_ok, crc_err
  );

  modport slave (
    input  in_valid, d, sop, eop,
    output in_ready, out_valid, d_out, sop_out, eop_out, crc_ok, crc_err
  );
endinterface

// File: rtl/crc_stream.sv
// Streaming CRC over sop/eop framed DW-bit beats: appends the CRC as a trailer
// (MODE=0) or passes frames through and flags the residue check at eop (MODE=1).
module crc_stream #(
  parameter int               DW      = 2,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] XOROUT  = '1,
  parameter logic [CRC_W-1:0] RESIDUE = 32'hC704DD7B,
  parameter int               MODE    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  crc_stream_if.slave  bus
);

  localparam int K     = CRC_W / DW;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  if ((DW < 1) || ((CRC_W % DW) != 0)) begin : g_bad_dw
    $error("crc_stream: DW=%0d does not divide CRC_W=%0d", DW, CRC_W);
  end

  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

  state_t             state_reg, state_next;
  logic [CRC_W-1:0]   crc_reg, crc_next;
  logic [CRC_W-1:0]   trailer_reg, trailer_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               out_valid_reg, out_valid_next;
  logic [DW-1:0]      d_out_reg, d_out_next;
  logic               sop_out_reg, sop_out_next;
  logic               eop_out_reg, eop_out_next;
  logic               crc_ok_reg, crc_ok_next;
  logic               crc_err_reg, crc_err_next;
  logic               ready;
  logic               accept;
  logic [CRC_W-1:0]   crc_upd;

  // One LFSR step per beat bit, d[DW-1] first; a sop beat seeds from INIT.
  logic [CRC_W-1:0] crc_chain [DW+1];
  assign crc_chain[0] = bus.sop ? INIT : crc_reg;

  genvar gi;
  for (gi = 0; gi < DW; gi++) begin : g_bit
    logic fb;
    assign fb             = crc_chain[gi][CRC_W-1] ^ bus.d[DW-1-gi];
    assign crc_chain[gi+1] = {crc_chain[gi][CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  assign crc_upd = crc_chain[DW];
  assign ready   = (MODE != 0) ? 1'b1 : (state_reg != APPEND);
  assign accept  = bus.in_valid & ready;

  always_comb begin
    state_next     = state_reg;
    crc_next       = crc_reg;
    trailer_next   = trailer_reg;
    cnt_next       = cnt_reg;
    out_valid_next = 1'b0;
    d_out_next     = '0;
    sop_out_next   = 1'b0;
    eop_out_next   = 1'b0;
    crc_ok_next    = 1'b0;
    crc_err_next   = 1'b0;
    case (state_reg)
      IDLE, DATA: begin
        // Beats outside a frame are dropped; a sop inside a frame restarts it.
        if (accept && (bus.sop || (state_reg == DATA))) begin
          crc_next       = crc_upd;
          out_valid_next = 1'b1;
          d_out_next     = bus.d;
          sop_out_next   = bus.sop;
          state_next     = DATA;
          if (bus.eop) begin
            if (MODE == 0) begin
              state_next   = APPEND;
              cnt_next     = '0;
              trailer_next = crc_upd ^ XOROUT;
            end else begin
              state_next   = IDLE;
              eop_out_next = 1'b1;
              crc_ok_next  = (crc_upd == RESIDUE);
              crc_err_next = (crc_upd != RESIDUE);
            end
          end
        end
      end
      APPEND: begin
        out_valid_next = 1'b1;
        d_out_next     = trailer_reg[CRC_W-1 -: DW];
        trailer_next   = trailer_reg << DW;
        cnt_next       = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(K - 1)) begin
          eop_out_next = 1'b1;
          cnt_next     = '0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      crc_reg       <= INIT;
      trailer_reg   <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      d_out_reg     <= '0;
      sop_out_reg   <= 1'b0;
      eop_out_reg   <= 1'b0;
      crc_ok_reg    <= 1'b0;
      crc_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      crc_reg       <= crc_next;
      trailer_reg   <= trailer_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      d_out_reg     <= d_out_next;
      sop_out_reg   <= sop_out_next;
      eop_out_reg   <= eop_out_next;
      crc_ok_reg    <= crc_ok_next;
      crc_err_reg   <= crc_err_next;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.d_out     = d_out_reg;
  assign bus.sop_out   = sop_out_reg;
  assign bus.eop_out   = eop_out_reg;
  assign bus.crc_ok    = crc_ok_reg;
  assign bus.crc_err   = crc_err_reg;

endmodule
